// File: rtl/asiclab_tx_pkg.sv
// Shared types and limits for the asiclab serial transmitter.
// Frame layout: start bit, 8 data bits sent LSB first, stop bit.
package asiclab_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int FRAME_BITS       = 10;
  localparam int MIN_CLKS_PER_BIT = 2;
  localparam int MAX_CLKS_PER_BIT = 65535;

endpackage

// File: rtl/asiclab_baud_tick.sv
// Bit-period down-counter. It pulses bit_end on the last cycle of each bit period.
// A restart reloads the counter so that a new frame begins on a full period.
module asiclab_baud_tick
  import asiclab_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_end
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] RELOAD = W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < MIN_CLKS_PER_BIT ||
      CLKS_PER_BIT > MAX_CLKS_PER_BIT) begin : g_bad_param
    $error("asiclab_baud_tick: CLKS_PER_BIT out of range");
  end

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q - W'(1);
    if (restart || cnt_q == '0) begin
      cnt_d = RELOAD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end = (cnt_q == '0);

endmodule

// File: rtl/asiclab_serial_tx.sv
// Serial frame transmitter with a valid/ready byte input.
// All outputs are registered. The line idles high.
module asiclab_serial_tx
  import asiclab_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_line,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 3);

  tx_state_t  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_q, bit_d;
  logic       line_q, line_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       accept;
  logic       bit_end;

  assign accept = tx_valid & ready_q;

  asiclab_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(accept),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    line_d  = line_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        line_d  = 1'b1;
        if (accept) begin
          state_d = START;
          shift_d = tx_data;
          bit_d   = '0;
          line_d  = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          line_d  = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
            line_d  = 1'b1;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            line_d  = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          line_d  = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      line_q  <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      line_q  <= line_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx_ready = ready_q;
  assign tx_line  = line_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
